// File: rtl/if_id_queue_if.sv
// Fetch-to-decode queue signal bundle: fetch/cache inputs, decode handshake and status.
// master drives the fetch side and decode ready; slave is the queue itself.
interface if_id_queue_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 3
);
   logic [DATA_W-1:0] instr_in;
   logic              hit_in;
   logic [DATA_W-1:0] pc_next_in;
   logic              flush;
   logic              id_ready;
   logic [DATA_W-1:0] instr_out;
   logic [DATA_W-1:0] pc_next_out;
   logic              valid_out;
   logic              full;
   logic [CNT_W-1:0]  count;

   modport master (
      output instr_in, hit_in, pc_next_in, flush, id_ready,
      input  instr_out, pc_next_out, valid_out, full, count
   );

   modport slave (
      input  instr_in, hit_in, pc_next_in, flush, id_ready,
      output instr_out, pc_next_out, valid_out, full, count
   );
endinterface

// File: rtl/if_id_queue.sv
// Circular instruction queue between fetch and decode with flush on taken branch.
// full/count/valid derive from registered state only, so fetch can gate its PC on full.
module if_id_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned CNT_W  = 3
) (
   input logic           clk,
   input logic           rst_n,
   if_id_queue_if.slave  q
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] instr_mem [DEPTH];
   logic [DATA_W-1:0] pc_mem    [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              valid;
   logic              push;
   logic              pop;

   assign full  = (count == CNT_W'(DEPTH));
   assign valid = (count != '0);
   assign push  = q.hit_in & ~full & ~q.flush;
   assign pop   = valid & q.id_ready & ~q.flush;

   // Storage needs no reset: reads are masked by valid.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= q.instr_in;
         pc_mem[wr_ptr]    <= q.pc_next_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (q.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      q.instr_out   = '0;
      q.pc_next_out = '0;
      if (valid) begin
         q.instr_out   = instr_mem[rd_ptr];
         q.pc_next_out = pc_mem[rd_ptr];
      end
   end

   assign q.valid_out = valid;
   assign q.full      = full;
   assign q.count     = count;
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, fill/drain, streaming, flush, full+pop+hit, wrap.
module tb_if_id_queue;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int unsigned total = 0;
   int unsigned bad = 0;

   if_id_queue_if #(.DATA_W(16), .CNT_W(3)) bus ();

   if_id_queue #(.DEPTH(4), .DATA_W(16), .CNT_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic hit, input logic [15:0] ins, input logic [15:0] pcn,
                        input logic rdy, input logic fl);
      bus.hit_in     = hit;
      bus.instr_in   = ins;
      bus.pc_next_in = pcn;
      bus.id_ready   = rdy;
      bus.flush      = fl;
   endtask

   task automatic check_empty(input string tag);
      check({tag, ".count"}, 32'(bus.count), 0);
      check({tag, ".valid"}, 32'(bus.valid_out), 0);
      check({tag, ".instr"}, 32'(bus.instr_out), 0);
      check({tag, ".pc"}, 32'(bus.pc_next_out), 0);
   endtask

   logic [15:0] model [$];
   int unsigned pushed;

   initial begin
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      #12;
      check_empty("reset");
      check("reset.full", 32'(bus.full), 0);
      rst_n = 1'b1;
      step();

      // fill with decode stalled
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 16'(16'h1111 * i), 16'(i), 1'b0, 1'b0);
         step();
         check("fill.count", 32'(bus.count), 32'(i));
         check("fill.head", 32'(bus.instr_out), 32'h1111);
      end
      check("fill.full", 32'(bus.full), 1);
      drive(1'b1, 16'h5555, 16'h0005, 1'b0, 1'b0);
      step();
      check("fill.5th.count", 32'(bus.count), 4);
      // drain
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         check("drain.valid", 32'(bus.valid_out), 1);
         check("drain.instr", 32'(bus.instr_out), 32'(16'h1111 * i));
         check("drain.pc", 32'(bus.pc_next_out), 32'(i));
         step();
      end
      check_empty("drain.end");
      check("drain.full", 32'(bus.full), 0);

      // streaming: one-cycle latency, occupancy settles at 1
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 16'(16'h0100 + i), 16'(16'h0200 + i), 1'b1, 1'b0);
         step();
         check("stream.count", 32'(bus.count), 1);
         check("stream.instr", 32'(bus.instr_out), 32'(16'h0100 + i));
         check("stream.pc", 32'(bus.pc_next_out), 32'(16'h0200 + i));
      end
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      step();
      check_empty("stream.end");

      // flush beats same-cycle push and pop
      drive(1'b1, 16'hB001, 16'h0011, 1'b0, 1'b0);
      step();
      drive(1'b1, 16'hB002, 16'h0012, 1'b0, 1'b0);
      step();
      check("flush.pre.count", 32'(bus.count), 2);
      drive(1'b1, 16'hB003, 16'h0013, 1'b1, 1'b1);
      step();
      check_empty("flush");
      drive(1'b1, 16'hC001, 16'h0021, 1'b0, 1'b0);
      step();
      check("flush.after.count", 32'(bus.count), 1);
      check("flush.after.instr", 32'(bus.instr_out), 32'hC001);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      step();
      check_empty("flush.drain");

      // full + pop + hit: push refused, re-presented next cycle
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 16'(16'hD000 + i), 16'(16'h0030 + i), 1'b0, 1'b0);
         step();
      end
      check("fph.full", 32'(bus.full), 1);
      drive(1'b1, 16'hAAAA, 16'h00AA, 1'b1, 1'b0);
      step();
      check("fph.count1", 32'(bus.count), 3);
      check("fph.head1", 32'(bus.instr_out), 32'hD002);
      step();
      check("fph.count2", 32'(bus.count), 3);
      check("fph.head2", 32'(bus.instr_out), 32'hD003);
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      step();
      check("fph.head3", 32'(bus.instr_out), 32'hD004);
      step();
      check("fph.head4", 32'(bus.instr_out), 32'hAAAA);
      check("fph.pc4", 32'(bus.pc_next_out), 32'h00AA);
      step();
      check_empty("fph.end");

      // asynchronous reset mid-stream
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 16'(16'hE000 + i), 16'(i), 1'b0, 1'b0);
         step();
      end
      drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
      check("rst.pre.count", 32'(bus.count), 3);
      #1 rst_n = 1'b0;
      #1;
      check_empty("rst.async");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check_empty("rst.after");

      // wrap: 10 pushes interleaved with pops, order tracked by a model queue
      pushed = 0;
      for (int c = 0; c < 40; c++) begin
         logic hit, rdy, do_push, do_pop;
         hit = (pushed < 10) && ((c % 3) != 2);
         rdy = (c % 2) == 0;
         drive(hit, 16'(16'hF000 + pushed), 16'(16'h0100 + pushed), rdy, 1'b0);
         check("wrap.count", 32'(bus.count), 32'(model.size()));
         check("wrap.valid", 32'(bus.valid_out), 32'(model.size() != 0));
         if (model.size() != 0)
            check("wrap.head", 32'(bus.instr_out), 32'(model[0]));
         do_pop  = rdy && (model.size() != 0);
         do_push = hit && (model.size() < 4);
         step();
         if (do_pop) void'(model.pop_front());
         if (do_push) begin
            model.push_back(16'(16'hF000 + pushed));
            pushed++;
         end
      end
      check("wrap.pushed", 32'(pushed), 10);
      check_empty("wrap.end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
